// File: rtl/contador_pkg.sv
// Shared constants and helpers for the modulo counter.
// Direction/mode encodings and the load clamp function.
package contador_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Out-of-range load values clamp to the top of the count range.
  function automatic int unsigned clamp_load(
    input int unsigned d,
    input int unsigned modulo
  );
    return (d < modulo) ? d : modulo - 1;
  endfunction

endpackage

// File: rtl/contador_modulo_next.sv
// Next-state logic for the modulo counter.
// Pure combinational: clr > load > en > hold.
module contador_modulo_next
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] next_q_o,
  output logic             wrap_evt_o,
  output logic             sat_evt_o
);

  // One extra bit so q+1 cannot overflow at MODULO = 2**WIDTH.
  localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULO - 1);

  logic [WIDTH:0] q_x;
  assign q_x = {1'b0, q_i};

  // Prioritised next-state and event selection.
  always_comb begin
    next_q_o   = q_i;
    wrap_evt_o = 1'b0;
    sat_evt_o  = 1'b0;
    priority case (1'b1)
      clr_i: begin
        next_q_o = '0;
      end
      load_i: begin
        next_q_o = WIDTH'(clamp_load(32'(d_i), MODULO));
      end
      en_i: begin
        if (up_i == DIR_UP) begin
          if (q_x < TOP) begin
            next_q_o = WIDTH'(q_x + 1'b1);
          end else if (sat_i == MODE_SAT) begin
            sat_evt_o = 1'b1;
          end else begin
            next_q_o   = '0;
            wrap_evt_o = 1'b1;
          end
        end else begin
          if (q_x != '0) begin
            next_q_o = WIDTH'(q_x - 1'b1);
          end else if (sat_i == MODE_SAT) begin
            sat_evt_o = 1'b1;
          end else begin
            next_q_o   = WIDTH'(TOP);
            wrap_evt_o = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/contador_sincrono_modulo.sv
// Parametrised synchronous up/down modulo-N counter.
// Registers, async reset and terminal-count flag.
module contador_sincrono_modulo
  import contador_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RST_VAL);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1 || MODULO < 2 || ((MODULO - 1) >> WIDTH) != 0) begin : g_bad_mod
    $error("contador_sincrono_modulo: MODULO out of range");
  end
  if (RST_VAL < 0 || RST_VAL >= MODULO) begin : g_bad_rst
    $error("contador_sincrono_modulo: RST_VAL out of range");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             sat_hit_q, sat_hit_d;

  contador_modulo_next #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_next (
    .q_i        (cnt_q),
    .en_i       (en),
    .up_i       (up),
    .sat_i      (sat),
    .load_i     (load),
    .d_i        (d),
    .clr_i      (clr),
    .next_q_o   (cnt_d),
    .wrap_evt_o (wrap_d),
    .sat_evt_o  (sat_hit_d)
  );

  // Count and event-pulse registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= RV;
      wrap_q    <= 1'b0;
      sat_hit_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      sat_hit_q <= sat_hit_d;
    end
  end

  // Terminal count warns that the next enabled edge wraps or saturates.
  always_comb begin
    tc = 1'b0;
    if (en) begin
      tc = (up == DIR_UP) ? (cnt_q == TOP) : (cnt_q == '0);
    end
  end

  assign q       = cnt_q;
  assign wrap    = wrap_q;
  assign sat_hit = sat_hit_q;

endmodule

// File: tb/tb_contador_sincrono_modulo.sv
// Scoreboard bench for contador_sincrono_modulo.
// Two instances (MODULO 10 and 16) share one stimulus stream.
module tb_contador_sincrono_modulo;

  localparam int W  = 4;
  localparam int MA = 10;
  localparam int RA = 0;
  localparam int MB = 16;
  localparam int RB = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         sat = 1'b0;

  logic [W-1:0] q_a, q_b;
  logic         tc_a, tc_b, wrap_a, wrap_b, sh_a, sh_b;

  contador_sincrono_modulo #(.WIDTH(W), .MODULO(MA), .RST_VAL(RA)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .en(en),
    .up(up), .sat(sat), .q(q_a), .tc(tc_a), .wrap(wrap_a), .sat_hit(sh_a)
  );

  contador_sincrono_modulo #(.WIDTH(W), .MODULO(MB), .RST_VAL(RB)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d), .en(en),
    .up(up), .sat(sat), .q(q_b), .tc(tc_b), .wrap(wrap_b), .sat_hit(sh_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre_qa;
    int pre_qb;
    bit pre_tca;
    bit pre_tcb;
    int post_qa;
    int post_qb;
    bit post_wa;
    bit post_wb;
    bit post_sa;
    bit post_sb;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;
  int cur_a = RA;
  int cur_b = RB;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the counting rules, plain integer math.
  function automatic void model(
    input int cur, input int m, input int rv,
    input bit r, input bit c, input bit l, input int dv,
    input bit e, input bit u, input bit s,
    output int nq, output bit nw, output bit ns
  );
    nq = cur;
    nw = 1'b0;
    ns = 1'b0;
    if (r) nq = rv;
    else if (c) nq = 0;
    else if (l) nq = (dv < m) ? dv : m - 1;
    else if (e) begin
      if (u) begin
        if (cur + 1 < m) nq = cur + 1;
        else if (s) ns = 1'b1;
        else begin nq = (cur + 1) % m; nw = 1'b1; end
      end else begin
        if (cur - 1 >= 0) nq = cur - 1;
        else if (s) ns = 1'b1;
        else begin nq = (cur - 1 + m) % m; nw = 1'b1; end
      end
    end
  endfunction

  function automatic bit model_tc(input int cur, input int m, input bit e, input bit u);
    return e && (u ? (cur == m - 1) : (cur == 0));
  endfunction

  task automatic cyc(input bit r, input bit c, input bit l, input int dv,
                     input bit e, input bit u, input bit s);
    item_t it;
    int na, nb;
    bit wa, sa, wb, sbt;
    @(negedge clk);
    rst = r; clr = c; load = l; d = W'(dv); en = e; up = u; sat = s;
    if (r) begin cur_a = RA; cur_b = RB; end
    it.pre_qa  = cur_a;
    it.pre_qb  = cur_b;
    it.pre_tca = model_tc(cur_a, MA, e, u);
    it.pre_tcb = model_tc(cur_b, MB, e, u);
    model(cur_a, MA, RA, r, c, l, dv, e, u, s, na, wa, sa);
    model(cur_b, MB, RB, r, c, l, dv, e, u, s, nb, wb, sbt);
    it.post_qa = na; it.post_wa = wa; it.post_sa = sa;
    it.post_qb = nb; it.post_wb = wb; it.post_sb = sbt;
    cur_a = na;
    cur_b = nb;
    sb.push_back(it);
  endtask

  // Monitor: pre-edge q/tc, then post-edge q/wrap/sat_hit.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check("q_a_pre", int'(q_a), it.pre_qa);
        check("q_b_pre", int'(q_b), it.pre_qb);
        check("tc_a", int'(tc_a), int'(it.pre_tca));
        check("tc_b", int'(tc_b), int'(it.pre_tcb));
        @(posedge clk);
        #1;
        check("q_a", int'(q_a), it.post_qa);
        check("q_b", int'(q_b), it.post_qb);
        check("wrap_a", int'(wrap_a), int'(it.post_wa));
        check("wrap_b", int'(wrap_b), int'(it.post_wb));
        check("sat_hit_a", int'(sh_a), int'(it.post_sa));
        check("sat_hit_b", int'(sh_b), int'(it.post_sb));
      end
    end
  end

  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 1, 0);
    repeat (12) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    repeat (11) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    repeat (19) cyc(0, 0, 0, 0, 1, 1, 1);
    repeat (20) cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 7, 1, 1, 0);
    cyc(0, 0, 1, 13, 1, 1, 0);
    cyc(0, 1, 1, 7, 1, 1, 0);
    cyc(0, 0, 1, 5, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 15, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 3, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1'(i), 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, ~1'(i), 0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(19) == 0),
          ($urandom_range(9) == 0), int'($urandom_range(15)),
          ($urandom_range(3) != 0), 1'($urandom),
          ($urandom_range(3) == 0));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
